execute_cycle: RTL and testbench

//   Execute stage of the 5-stage RV32I pipeline; consumes the registered ID/EX bundle of the decode stage.

---
 rtl/execute_cycle.sv | 143 ++++++++++++++
 tb/tb_execute_cycle.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RV32I pipeline: operand forwarding, ALU, beq
// resolution and branch target, followed by the EX/MEM pipeline register.
module execute_cycle #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // ID/EX bundle
  input  logic              regwritee,
  input  logic              alusrce,
  input  logic              memwritee,
  input  logic              resultsrce,
  input  logic              branche,
  input  logic [2:0]        alucontrole,
  input  logic [DATA_W-1:0] rd1_e,
  input  logic [DATA_W-1:0] rd2_e,
  input  logic [DATA_W-1:0] imm_ext_e,
  input  logic [4:0]        rd_e,
  input  logic [DATA_W-1:0] pce,
  input  logic [DATA_W-1:0] pcplus4e,
  // hazard unit / writeback
  input  logic [1:0]        forwardae,
  input  logic [1:0]        forwardbe,
  input  logic [DATA_W-1:0] resultw,
  // branch redirect to fetch
  output logic              pcsrce,
  output logic [DATA_W-1:0] pctargete,
  // EX/MEM bundle
  output logic              regwritem,
  output logic              memwritem,
  output logic              resultsrcm,
  output logic [4:0]        rdm,
  output logic [DATA_W-1:0] aluresultm,
  output logic [DATA_W-1:0] writedatam,
  output logic [DATA_W-1:0] pcplus4m
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  logic              regwrite_q, regwrite_d;
  logic              memwrite_q, memwrite_d;
  logic              resultsrc_q, resultsrc_d;
  logic [4:0]        rd_q, rd_d;
  logic [DATA_W-1:0] aluresult_q, aluresult_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic [DATA_W-1:0] pcplus4_q, pcplus4_d;

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] srca;
  logic [DATA_W-1:0] srcb;
  logic [DATA_W-1:0] alu_result;
  logic              zero;

  // The MEM forward source is the registered result, so forwarding never
  // closes a combinational loop through the ALU.
  always_comb begin
    fwd_a = rd1_e;
    case (forwardae)
      FWD_WB:  fwd_a = resultw;
      FWD_MEM: fwd_a = aluresult_q;
      default: fwd_a = rd1_e;
    endcase
  end

  always_comb begin
    fwd_b = rd2_e;
    case (forwardbe)
      FWD_WB:  fwd_b = resultw;
      FWD_MEM: fwd_b = aluresult_q;
      default: fwd_b = rd2_e;
    endcase
  end

  assign srca = fwd_a;
  assign srcb = alusrce ? imm_ext_e : fwd_b;

  always_comb begin
    alu_result = '0;
    case (alucontrole)
      ALU_ADD: alu_result = srca + srcb;
      ALU_SUB: alu_result = srca - srcb;
      ALU_AND: alu_result = srca & srcb;
      ALU_OR:  alu_result = srca | srcb;
      ALU_XOR: alu_result = srca ^ srcb;
      ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      default: alu_result = '0;
    endcase
  end

  assign zero      = (alu_result == '0);
  assign pcsrce    = branche & zero;
  assign pctargete = pce + imm_ext_e;

  // Store data always takes the forwarded rs2, even when B comes from imm.
  always_comb begin
    regwrite_d  = regwritee;
    memwrite_d  = memwritee;
    resultsrc_d = resultsrce;
    rd_d        = rd_e;
    aluresult_d = alu_result;
    writedata_d = fwd_b;
    pcplus4_d   = pcplus4e;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      resultsrc_q <= 1'b0;
      rd_q        <= '0;
      aluresult_q <= '0;
      writedata_q <= '0;
      pcplus4_q   <= '0;
    end else begin
      regwrite_q  <= regwrite_d;
      memwrite_q  <= memwrite_d;
      resultsrc_q <= resultsrc_d;
      rd_q        <= rd_d;
      aluresult_q <= aluresult_d;
      writedata_q <= writedata_d;
      pcplus4_q   <= pcplus4_d;
    end
  end

  assign regwritem  = regwrite_q;
  assign memwritem  = memwrite_q;
  assign resultsrcm = resultsrc_q;
  assign rdm        = rd_q;
  assign aluresultm = aluresult_q;
  assign writedatam = writedata_q;
  assign pcplus4m   = pcplus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle: a driver pushes the expected EX/MEM bundle
// per issued cycle and a monitor pops and compares after each capture edge.
module tb_execute_cycle;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          regwritee, alusrce, memwritee, resultsrce, branche;
  logic [2:0]    alucontrole;
  logic [W-1:0]  rd1_e, rd2_e, imm_ext_e, pce, pcplus4e, resultw;
  logic [4:0]    rd_e;
  logic [1:0]    forwardae, forwardbe;
  logic          pcsrce;
  logic [W-1:0]  pctargete;
  logic          regwritem, memwritem, resultsrcm;
  logic [4:0]    rdm;
  logic [W-1:0]  aluresultm, writedatam, pcplus4m;

  typedef struct packed {
    logic         regwrite;
    logic         memwrite;
    logic         resultsrc;
    logic [4:0]   rd;
    logic [W-1:0] alu;
    logic [W-1:0] wd;
    logic [W-1:0] pc4;
  } exmem_t;

  exmem_t exp_q[$];
  int total = 0;
  int bad = 0;

  execute_cycle #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .regwritee(regwritee), .alusrce(alusrce), .memwritee(memwritee),
    .resultsrce(resultsrce), .branche(branche), .alucontrole(alucontrole),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .rd_e(rd_e),
    .pce(pce), .pcplus4e(pcplus4e), .forwardae(forwardae), .forwardbe(forwardbe),
    .resultw(resultw), .pcsrce(pcsrce), .pctargete(pctargete),
    .regwritem(regwritem), .memwritem(memwritem), .resultsrcm(resultsrcm),
    .rdm(rdm), .aluresultm(aluresultm), .writedatam(writedatam), .pcplus4m(pcplus4m)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver helpers
  task automatic set_defaults();
    rst = 1'b0; regwritee = 1'b1; alusrce = 1'b1; memwritee = 1'b0;
    resultsrce = 1'b0; branche = 1'b0; alucontrole = 3'b000;
    rd1_e = '0; rd2_e = '0; imm_ext_e = '0; rd_e = 5'd1;
    pce = 32'h0000_0040; pcplus4e = 32'h0000_0044;
    forwardae = 2'b00; forwardbe = 2'b00; resultw = '0;
  endtask

  // Called after inputs are driven; the bundle is captured at the next posedge.
  task automatic issue(input string name, input logic [W-1:0] exp_alu, input logic [W-1:0] exp_wd,
                       input logic exp_pcsrc, input logic [W-1:0] exp_target);
    exmem_t e;
    #1;
    check({name, ".pcsrce"}, {31'b0, pcsrce}, {31'b0, exp_pcsrc});
    check({name, ".pctargete"}, pctargete, exp_target);
    if (rst) begin
      e = '0;
    end else begin
      e.regwrite  = regwritee;
      e.memwrite  = memwritee;
      e.resultsrc = resultsrce;
      e.rd        = rd_e;
      e.alu       = exp_alu;
      e.wd        = exp_wd;
      e.pc4       = pcplus4e;
    end
    exp_q.push_back(e);
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    exmem_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("regwritem", {31'b0, regwritem}, {31'b0, e.regwrite});
      check("memwritem", {31'b0, memwritem}, {31'b0, e.memwrite});
      check("resultsrcm", {31'b0, resultsrcm}, {31'b0, e.resultsrc});
      check("rdm", {27'b0, rdm}, {27'b0, e.rd});
      check("aluresultm", aluresultm, e.alu);
      check("writedatam", writedatam, e.wd);
      check("pcplus4m", pcplus4m, e.pc4);
    end
  end

  initial begin
    set_defaults();
    rst = 1'b1;

    // 1. reset with nonzero inputs held for two edges
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b1; regwritee = 1'b1; memwritee = 1'b1; resultsrce = 1'b1;
      rd1_e = 32'h11; rd2_e = 32'h22; imm_ext_e = 32'h4; rd_e = 5'd7;
      pce = 32'h200; pcplus4e = 32'h204; alusrce = 1'b1;
      issue("rst", 32'h0, 32'h0, 1'b0, 32'h204);
    end

    // first capture after release
    @(negedge clk); set_defaults();
    rd1_e = 32'h11; rd2_e = 32'h22; imm_ext_e = 32'h4; rd_e = 5'd7; memwritee = 1'b1;
    issue("first", 32'h15, 32'h22, 1'b0, 32'h44);

    // 2. ALU sweep
    @(negedge clk); set_defaults(); rd1_e = 32'h7FFF_FFFF; imm_ext_e = 32'h1;
    issue("add_ovf", 32'h8000_0000, 32'h0, 1'b0, 32'h41);
    @(negedge clk); set_defaults(); alucontrole = 3'b001; rd1_e = 32'h0; imm_ext_e = 32'h1; rd_e = 5'd3;
    issue("sub", 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h41);
    @(negedge clk); set_defaults(); alucontrole = 3'b101; rd1_e = 32'hFFFF_FFFF; imm_ext_e = 32'h1;
    issue("slt_neg", 32'h1, 32'h0, 1'b0, 32'h41);
    @(negedge clk); set_defaults(); alucontrole = 3'b101; rd1_e = 32'h1; imm_ext_e = 32'hFFFF_FFFF;
    issue("slt_pos", 32'h0, 32'h0, 1'b0, 32'h3F);
    @(negedge clk); set_defaults(); alucontrole = 3'b010; rd1_e = 32'hF0F0; imm_ext_e = 32'h0FF0;
    issue("and", 32'h00F0, 32'h0, 1'b0, 32'h1030);
    @(negedge clk); set_defaults(); alucontrole = 3'b011; rd1_e = 32'hF0F0; imm_ext_e = 32'h0FF0;
    issue("or", 32'hFFF0, 32'h0, 1'b0, 32'h1030);
    @(negedge clk); set_defaults(); alucontrole = 3'b100; rd1_e = 32'hF0F0; imm_ext_e = 32'h0FF0;
    issue("xor", 32'hFF00, 32'h0, 1'b0, 32'h1030);
    @(negedge clk); set_defaults(); alucontrole = 3'b110; rd1_e = 32'hF0F0; imm_ext_e = 32'h0FF0;
    issue("op110", 32'h0, 32'h0, 1'b0, 32'h1030);
    @(negedge clk); set_defaults(); alucontrole = 3'b111; rd1_e = 32'hF0F0; imm_ext_e = 32'h0FF0; branche = 1'b1;
    issue("op111", 32'h0, 32'h0, 1'b1, 32'h1030);

    // 3. forwarding: prime aluresultm=20 first
    @(negedge clk); set_defaults(); rd1_e = 32'd19; imm_ext_e = 32'd1;
    issue("prime20", 32'd20, 32'h0, 1'b0, 32'h41);
    @(negedge clk); set_defaults(); rd1_e = 32'd5; resultw = 32'd9; imm_ext_e = 32'd1; forwardae = 2'b10;
    issue("fwd_mem", 32'd21, 32'h0, 1'b0, 32'h41);
    @(negedge clk); set_defaults(); rd1_e = 32'd5; resultw = 32'd9; imm_ext_e = 32'd1; forwardae = 2'b01;
    issue("fwd_wb", 32'd10, 32'h0, 1'b0, 32'h41);
    @(negedge clk); set_defaults(); rd1_e = 32'd5; resultw = 32'd9; imm_ext_e = 32'd1; forwardae = 2'b11;
    issue("fwd_11", 32'd6, 32'h0, 1'b0, 32'h41);

    // 4. beq taken / not taken
    @(negedge clk); set_defaults(); alusrce = 1'b0; alucontrole = 3'b001; branche = 1'b1; regwritee = 1'b0;
    rd1_e = 32'h1234; rd2_e = 32'h1234; pce = 32'h100; pcplus4e = 32'h104; imm_ext_e = 32'hFFFF_FFF0;
    issue("beq_taken", 32'h0, 32'h1234, 1'b1, 32'h0F0);
    @(negedge clk); rd2_e = 32'h1235;
    issue("beq_not", 32'hFFFF_FFFF, 32'h1235, 1'b0, 32'h0F0);

    // 5. store data forwarded from WB while B comes from imm
    @(negedge clk); set_defaults(); memwritee = 1'b1; regwritee = 1'b0; forwardbe = 2'b01;
    resultw = 32'hDEAD; rd1_e = 32'h1000; rd2_e = 32'h5555; imm_ext_e = 32'h8; rd_e = 5'd0;
    issue("store_fwd", 32'h1008, 32'hDEAD, 1'b0, 32'h48);

    // 6. back-to-back dependency doubling, then reset mid-stream
    @(negedge clk); set_defaults(); rd1_e = 32'd3; imm_ext_e = 32'd0; rd_e = 5'd1;
    issue("dep0", 32'd3, 32'h0, 1'b0, 32'h40);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); set_defaults(); alusrce = 1'b0; forwardae = 2'b10; forwardbe = 2'b10;
      rd1_e = 32'hAAAA; rd2_e = 32'hBBBB;
      issue("dep_dbl", 32'd3 << i, 32'd3 << (i - 1), 1'b0, 32'h40);
    end
    @(negedge clk); rst = 1'b1;
    issue("dep_rst", 32'h0, 32'h0, 1'b0, 32'h40);
    @(negedge clk); rst = 1'b0;
    issue("after_rst", 32'h0, 32'h0, 1'b0, 32'h40);
    @(negedge clk); set_defaults(); rd1_e = 32'd7; imm_ext_e = 32'd2; pcplus4e = 32'h48;
    issue("resume", 32'd9, 32'h0, 1'b0, 32'h42);

    // drain the scoreboard, bounded
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
